reorder_buffer: RTL
===================

Name: reorder_buffer

Overview:
- 16-entry circular reorder buffer (ROB) for the OoO core; sits between issue/CDB and architectural commit.
- Allocates a ROB tag per issued instruction and captures results broadcast on the CDB.
- Forwards ready values to the issue-stage operand read.
- Retires in order at the head, driving the register-status and register-file commit interface (commit_dest, commit_ROB, RegWrite) and the mispredict flush.

Parameters:
DEPTH, 16, number of entries; fixed to match the 4-bit ROB tag
XLEN, 32, data width of result values

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high; clears all state
issue_valid  input  1  instruction issued this cycle; ignored when full or flush
issue_type  input  2  00 reg-writing op, 01 store, 10 branch, 11 reserved (treated as 00)
issue_dest  input  5  destination register (x0 permitted; RegWrite suppressed at commit)
full  output  1  count == DEPTH
issue_ROB  output  4  tag allocated this cycle (= tail)
cdb_valid  input  1  result broadcast
cdb_ROB  input  4  tag of broadcast result
cdb_value  input  XLEN  result; for branches, the correct next PC
cdb_mispredict  input  1  branch resolved opposite to prediction (branches only)
Q_j, Q_k  input  4  operand tags from regstat
j_ready, k_ready  output  1  tagged entry holds a valid result
j_value, k_value  output  XLEN  result of tagged entry
commit_valid  output  1  head retires this cycle
RegWrite  output  1  commit_valid & type 00 & dest != 0
commit_dest  output  5  head destination register
commit_ROB  output  4  head tag
commit_value  output  XLEN  head result
mem_write  output  1  commit_valid & type 01 (store buffer releases entry commit_ROB)
flush  output  1  commit_valid & head is a branch with mispredict set
flush_pc  output  XLEN  head cdb_value when flush

Behaviour:
- Reset (async): all entry valid/ready/mispredict bits = 0; head = tail = 0; count = 0.
  - Outputs: full = 0, issue_ROB = 0, all commit/flush outputs = 0.
- Entry fields: valid, ready, type, dest, value, mispredict.
- Allocate: issue_valid & ~full & ~flush
  - Next edge: entry[tail] <= {valid=1, ready=0, type, dest, mispredict=0}; tail++ (mod 16).
  - issue_ROB = tail combinationally, so regstat latches it in the same cycle.
- CDB write: cdb_valid & entry[cdb_ROB].valid
  - Next edge: ready=1, value=cdb_value, mispredict=cdb_mispredict.
  - cdb_valid to an invalid entry is ignored.
- Commit:
  - commit_valid = entry[head].valid & entry[head].ready; combinational, same cycle the head becomes ready.
  - Next edge: entry[head].valid = 0, head++.
  - Max one commit per cycle.
  - A CDB write to the head takes effect at the edge, so commit occurs the following cycle; there is no CDB-to-commit bypass.
- Count:
  - +1 on allocate, −1 on commit; simultaneous allocate and commit leaves count unchanged.
  - full blocks issue even if a commit occurs the same cycle; there is no full bypass.
- Flush (mispredicted branch at head):
  - flush = 1 for that cycle; the branch itself retires (commit_valid = 1, RegWrite = 0).
  - Next edge: all entries invalidated; head = tail = count = 0.
  - Same-cycle issue is dropped; same-cycle CDB write is discarded.
  - flush drives regstat reset.
- Operand read, per port:
  - If cdb_valid & cdb_ROB == Q: ready = 1, value = cdb_value (CDB bypass).
  - Else ready = entry[Q].valid & entry[Q].ready, value = entry[Q].value.
  - An invalid entry returns ready = 0, value = 0.
- Wrap-around: head/tail are 4-bit and wrap 15→0; full/empty are distinguished by count (0..16, 5 bits).
- Correctly predicted branch commits with flush = 0, RegWrite = 0, mem_write = 0.

Test Plan:
- Reset mid-operation with 5 entries allocated → same cycle full = 0, commit_valid = 0; next issue gets issue_ROB = 0.
- Issue 3 ops (dest x5, x6, x7) → tags 0, 1, 2. CDB tag 1 value 0xAA, then tag 0 value 0x55 → commits in order: x5/0x55/ROB0, then x6/0xAA/ROB1, one per cycle; x7 does not commit.
- Fill 16 without commits → full = 1, 17th issue ignored. Commit one while issuing the same cycle → issue ignored; next cycle tag 0 allocated (wrap), count = 16.
- Q_j = 3 with cdb_valid, cdb_ROB = 3, value 0x1234 → j_ready = 1, j_value = 0x1234 the same cycle; Q_k = 4 (unready) → k_ready = 0.
- Branch at tag 2 with mispredict, cdb_value 0x400, 2 younger ops, issue_valid high at commit → flush = 1, flush_pc = 0x400, RegWrite = 0; next cycle count = 0, head = tail = 0, no commits follow.
- Store then op to x0, both ready → mem_write = 1 with commit_ROB = store tag; x0 op commits with RegWrite = 0.

Source files
------------

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: allocates tags at issue, captures CDB results,
// forwards ready operands and retires in order at the head with mispredict flush.
module reorder_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [1:0]      issue_type,
  input  logic [4:0]      issue_dest,
  output logic            full,
  output logic [3:0]      issue_ROB,
  input  logic            cdb_valid,
  input  logic [3:0]      cdb_ROB,
  input  logic [XLEN-1:0] cdb_value,
  input  logic            cdb_mispredict,
  input  logic [3:0]      Q_j,
  input  logic [3:0]      Q_k,
  output logic            j_ready,
  output logic            k_ready,
  output logic [XLEN-1:0] j_value,
  output logic [XLEN-1:0] k_value,
  output logic            commit_valid,
  output logic            RegWrite,
  output logic [4:0]      commit_dest,
  output logic [3:0]      commit_ROB,
  output logic [XLEN-1:0] commit_value,
  output logic            mem_write,
  output logic            flush,
  output logic [XLEN-1:0] flush_pc
);

  localparam int unsigned TAG_W  = 4;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned DEST_W = 5;
  localparam int unsigned TYPE_W = 2;

  localparam logic [TYPE_W-1:0] TYPE_REG    = 2'b00;
  localparam logic [TYPE_W-1:0] TYPE_STORE  = 2'b01;
  localparam logic [TYPE_W-1:0] TYPE_BRANCH = 2'b10;
  localparam logic [TYPE_W-1:0] TYPE_RSVD   = 2'b11;

  logic              r_valid [DEPTH];
  logic              r_ready [DEPTH];
  logic              r_misp  [DEPTH];
  logic [TYPE_W-1:0] r_type  [DEPTH];
  logic [DEST_W-1:0] r_dest  [DEPTH];
  logic [XLEN-1:0]   r_value [DEPTH];

  logic [TAG_W-1:0]  r_head;
  logic [TAG_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_commit;
  logic              w_flush;
  logic              w_alloc;
  logic              w_cdb_wr;
  logic [TYPE_W-1:0] w_alloc_type;
  logic [CNT_W-1:0]  w_count_nxt;

  // Control decode for this cycle
  always_comb begin
    w_full       = (r_count == CNT_W'(DEPTH));
    w_commit     = r_valid[r_head] & r_ready[r_head];
    w_flush      = w_commit & (r_type[r_head] == TYPE_BRANCH) & r_misp[r_head];
    w_alloc      = issue_valid & ~w_full & ~w_flush;
    w_cdb_wr     = cdb_valid & r_valid[cdb_ROB];
    // reserved type behaves as a register-writing op
    w_alloc_type = (issue_type == TYPE_RSVD) ? TYPE_REG : issue_type;
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_alloc, w_commit})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Entry storage, pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_valid[i] <= 1'b0;
        r_ready[i] <= 1'b0;
        r_misp[i]  <= 1'b0;
        r_type[i]  <= '0;
        r_dest[i]  <= '0;
        r_value[i] <= '0;
      end
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_valid[i] <= 1'b0;
        r_ready[i] <= 1'b0;
        r_misp[i]  <= 1'b0;
      end
    end else begin
      if (w_cdb_wr) begin
        r_ready[cdb_ROB] <= 1'b1;
        r_value[cdb_ROB] <= cdb_value;
        r_misp[cdb_ROB]  <= cdb_mispredict;
      end
      if (w_commit) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + TAG_W'(1);
      end
      // tail slot is never valid when not full, so it cannot collide with a CDB write
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_ready[r_tail] <= 1'b0;
        r_misp[r_tail]  <= 1'b0;
        r_type[r_tail]  <= w_alloc_type;
        r_dest[r_tail]  <= issue_dest;
        r_value[r_tail] <= '0;
        r_tail          <= r_tail + TAG_W'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Issue and commit interface
  always_comb begin
    full         = w_full;
    issue_ROB    = r_tail;
    commit_valid = w_commit;
    RegWrite     = w_commit & (r_type[r_head] == TYPE_REG) & (r_dest[r_head] != '0);
    mem_write    = w_commit & (r_type[r_head] == TYPE_STORE);
    flush        = w_flush;
    commit_dest  = w_commit ? r_dest[r_head]  : '0;
    commit_ROB   = w_commit ? r_head          : '0;
    commit_value = w_commit ? r_value[r_head] : '0;
    flush_pc     = w_flush  ? r_value[r_head] : '0;
  end

  // Operand read with CDB bypass
  always_comb begin
    j_ready = 1'b0;
    j_value = '0;
    k_ready = 1'b0;
    k_value = '0;
    if (cdb_valid && (cdb_ROB == Q_j)) begin
      j_ready = 1'b1;
      j_value = cdb_value;
    end else if (r_valid[Q_j]) begin
      j_ready = r_ready[Q_j];
      j_value = r_value[Q_j];
    end
    if (cdb_valid && (cdb_ROB == Q_k)) begin
      k_ready = 1'b1;
      k_value = cdb_value;
    end else if (r_valid[Q_k]) begin
      k_ready = r_ready[Q_k];
      k_value = r_value[Q_k];
    end
  end

endmodule
